// File: rtl/load_unit_pkg.sv
// rtl/load_unit_pkg.sv - shared load encodings, exception codes and FSM states
// Purpose: access-size encodings (Word/Half/Byte), load exception codes,
//          load FSM state type and small request-classification helpers.
// Ports:   none (package).
package load_unit_pkg;

  localparam logic [2:0] Byte = 3'd0;
  localparam logic [2:0] Half = 3'd1;
  localparam logic [2:0] Word = 3'd2;

  localparam logic [1:0] EXC_NONE = 2'd0;
  localparam logic [1:0] EXC_ADEL = 2'd1;
  localparam logic [1:0] EXC_BUS  = 2'd2;
  localparam logic [1:0] EXC_TMO  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  function automatic logic type_known(input logic [2:0] t);
    return (t == Byte) || (t == Half) || (t == Word);
  endfunction

  function automatic logic misaligned(input logic [2:0] t, input logic [1:0] a);
    return ((t == Half) && a[0]) || ((t == Word) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/load_unit_if.sv
// rtl/load_unit_if.sv - pipeline load request, data bus and response signals
// Purpose: bundles the load request (ld_*), data-bus read port (bus_*) and
//          writeback response (rsp_*) of the load unit.
// Ports:   master = environment side (pipeline, bus slave, writeback);
//          slave  = load unit side.
interface load_unit_if;

  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_addr;
  logic [2:0]  ld_type;
  logic        ld_signed;

  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        bus_err;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_exc;

  modport master (
    output ld_valid, ld_addr, ld_type, ld_signed,
    input  ld_ready,
    input  bus_req, bus_addr,
    output bus_gnt, bus_rvalid, bus_rdata, bus_err,
    input  rsp_valid, rsp_data, rsp_exc,
    output rsp_ready
  );

  modport slave (
    input  ld_valid, ld_addr, ld_type, ld_signed,
    output ld_ready,
    output bus_req, bus_addr,
    input  bus_gnt, bus_rvalid, bus_rdata, bus_err,
    output rsp_valid, rsp_data, rsp_exc,
    input  rsp_ready
  );

endinterface

// File: rtl/load_extender.sv
// rtl/load_extender.sv - byte/halfword extraction with sign or zero extension
// Purpose: combinational lane select and extension of a read word; shared with
//          the bypass path.
// Ports:   data_r_in (32) read word, addr_low (2) byte offset, read_type (3)
//          access size, sign_ext (1) -> data_r_out (32) extended value
//          (0 for unknown access sizes).
module load_extender
  import load_unit_pkg::*;
(
  input  logic [31:0] data_r_in,
  input  logic [1:0]  addr_low,
  input  logic [2:0]  read_type,
  input  logic        sign_ext,
  output logic [31:0] data_r_out
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_low)
      2'd0:    byte_sel = data_r_in[7:0];
      2'd1:    byte_sel = data_r_in[15:8];
      2'd2:    byte_sel = data_r_in[23:16];
      default: byte_sel = data_r_in[31:24];
    endcase
    half_sel = addr_low[1] ? data_r_in[31:16] : data_r_in[15:0];

    case (read_type)
      Word:    data_r_out = data_r_in;
      Half:    data_r_out = {{16{sign_ext & half_sel[15]}}, half_sel};
      Byte:    data_r_out = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      default: data_r_out = 32'd0;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// rtl/load_unit.sv - MEM-stage load unit: align check, bus read, extend, hold
// Purpose: accepts one load at a time, fetches the containing word over a
//          variable-latency bus with a timeout, and holds the extended result
//          until writeback takes it.
// Ports:   clk, reset_n (async, active-low); lu (load_unit_if.slave) carrying
//          ld_* request, bus_* read port and rsp_* response.
module load_unit
  import load_unit_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  load_unit_if.slave  lu
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [31:0]     addr_q, addr_d;
  logic [2:0]      type_q, type_d;
  logic            sgn_q, sgn_d;
  logic [31:0]     data_q, data_d;
  logic [1:0]      exc_q, exc_d;
  logic [31:0]     ext_data;
  logic            tmo_hit;

  load_extender u_ext (
    .data_r_in  (lu.bus_rdata),
    .addr_low   (addr_q[1:0]),
    .read_type  (type_q),
    .sign_ext   (sgn_q),
    .data_r_out (ext_data)
  );

  // Last permitted REQ/WAIT cycle; a bus event in this cycle still wins.
  assign tmo_hit = (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    addr_d  = addr_q;
    type_d  = type_q;
    sgn_d   = sgn_q;
    data_d  = data_q;
    exc_d   = exc_q;

    case (state)
      IDLE: begin
        if (lu.ld_valid) begin
          addr_d = lu.ld_addr;
          type_d = lu.ld_type;
          sgn_d  = lu.ld_signed;
          cnt_d  = '0;
          data_d = 32'd0;
          exc_d  = EXC_NONE;
          if (!type_known(lu.ld_type)) begin
            state_d = RESP;
          end else if (misaligned(lu.ld_type, lu.ld_addr[1:0])) begin
            exc_d   = EXC_ADEL;
            state_d = RESP;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (lu.bus_gnt) begin
          state_d = WAIT;
          cnt_d   = cnt + CW'(1);
        end else if (tmo_hit) begin
          exc_d   = EXC_TMO;
          state_d = RESP;
        end else begin
          cnt_d   = cnt + CW'(1);
        end
      end
      WAIT: begin
        if (lu.bus_rvalid) begin
          state_d = RESP;
          if (lu.bus_err) begin
            exc_d = EXC_BUS;
          end else begin
            data_d = ext_data;
          end
        end else if (tmo_hit) begin
          exc_d   = EXC_TMO;
          state_d = RESP;
        end else begin
          cnt_d   = cnt + CW'(1);
        end
      end
      default: begin
        if (lu.rsp_ready) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= 32'd0;
      type_q <= Byte;
      sgn_q  <= 1'b0;
      data_q <= 32'd0;
      exc_q  <= EXC_NONE;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      addr_q <= addr_d;
      type_q <= type_d;
      sgn_q  <= sgn_d;
      data_q <= data_d;
      exc_q  <= exc_d;
    end
  end

  assign lu.ld_ready  = (state == IDLE);
  assign lu.bus_req   = (state == REQ);
  assign lu.bus_addr  = {addr_q[31:2], 2'b00};
  assign lu.rsp_valid = (state == RESP);
  assign lu.rsp_data  = data_q;
  assign lu.rsp_exc   = exc_q;

endmodule

// File: tb/tb_load_unit.sv
// tb/tb_load_unit.sv - scoreboard bench for load_unit with randomized loads
module tb_load_unit;
  import load_unit_pkg::*;

  localparam int TMO = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  load_unit_if lf();

  load_unit #(.TIMEOUT(TMO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .lu      (lf)
  );

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  exc;
  } rsp_t;
  rsp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: timing counted in cycles after accept (accept = cycle 0).
  // gd = REQ cycles before grant, rd = WAIT cycles before rvalid, -1 = never.
  function automatic void model(input logic [31:0] a, input logic [2:0] t, input logic s,
                                input logic [31:0] rdat, input int gd, input int rd,
                                input logic err, output logic [31:0] d, output logic [1:0] e,
                                output int first, output int reqc);
    logic [31:0] v;
    d = 0; e = EXC_NONE; first = 1; reqc = 0;
    if (!(t == Word || t == Half || t == Byte)) begin
      e = EXC_NONE;
    end else if ((t == Word && a[1:0] != 2'b00) || (t == Half && a[0])) begin
      e = EXC_ADEL;
    end else if (gd < 0 || gd + 1 > TMO) begin
      e = EXC_TMO; first = TMO + 1; reqc = TMO;
    end else begin
      reqc = gd + 1;
      if (rd < 0 || gd + rd + 2 > TMO) begin
        e = EXC_TMO; first = TMO + 1;
      end else begin
        first = gd + rd + 3;
        if (err) begin
          e = EXC_BUS;
        end else begin
          if (t == Word) v = rdat;
          else if (t == Half) begin
            v = (rdat >> (a[1] ? 16 : 0)) & 32'h0000_FFFF;
            if (s && v[15]) v = v | 32'hFFFF_0000;
          end else begin
            v = (rdat >> (8 * a[1:0])) & 32'h0000_00FF;
            if (s && v[7]) v = v | 32'hFFFF_FF00;
          end
          d = v;
        end
      end
    end
  endfunction

  // Monitor: every response handshake is compared against the scoreboard.
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      if (reset_n && lf.rsp_valid && lf.rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          r = exp_q.pop_front();
          check("rsp_data", lf.rsp_data, r.data);
          check("rsp_exc", {30'd0, lf.rsp_exc}, {30'd0, r.exc});
        end
      end
    end
  end

  task automatic run_load(input logic [31:0] a, input logic [2:0] t, input logic s,
                          input logic [31:0] rdat, input int gd, input int rd,
                          input logic err, input int hold);
    logic [31:0] d, d0;
    logic [1:0]  e, e0;
    int first_exp, reqc, rv_cycle, c, first;
    logic done, req_ok, addr_ok, stable_ok, pre_gnt;
    rsp_t r;
    model(a, t, s, rdat, gd, rd, err, d, e, first_exp, reqc);
    r.data = d; r.exc = e;
    exp_q.push_back(r);
    rv_cycle = (gd >= 0 && rd >= 0) ? gd + 2 + rd : -1;

    lf.ld_valid = 1'b1; lf.ld_addr = a; lf.ld_type = t; lf.ld_signed = s;
    @(posedge clk); #1;
    lf.ld_valid = 1'b0; lf.ld_addr = $urandom; lf.ld_type = 3'($urandom);

    c = 1; first = 0; done = 0; req_ok = 1; addr_ok = 1; stable_ok = 1; d0 = 0; e0 = 0;
    while (!done && c < 40) begin
      pre_gnt = (reqc > 0) && (c <= reqc) && !(gd >= 0 && c == gd + 1);
      lf.bus_gnt = (gd >= 0 && c == gd + 1);
      if (c == rv_cycle) begin
        lf.bus_rvalid = 1'b1; lf.bus_rdata = rdat; lf.bus_err = err;
      end else begin
        // Stray read data while requesting or holding a response must be ignored.
        lf.bus_rvalid = (pre_gnt || first != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        lf.bus_rdata = $urandom; lf.bus_err = 1'($urandom);
      end
      lf.rsp_ready = (hold == 0) || (first != 0 && c - first >= hold);
      @(negedge clk);
      if (lf.bus_req !== (c <= reqc)) req_ok = 0;
      if (lf.bus_req && lf.bus_addr !== {a[31:2], 2'b00}) addr_ok = 0;
      if (lf.rsp_valid) begin
        if (first == 0) begin
          first = c; d0 = lf.rsp_data; e0 = lf.rsp_exc;
        end else if (lf.rsp_data !== d0 || lf.rsp_exc !== e0) stable_ok = 0;
        if (lf.ld_ready) stable_ok = 0;
        if (lf.rsp_ready) done = 1;
      end
      @(posedge clk); #1;
      c++;
    end
    lf.bus_gnt = 0; lf.rsp_ready = 0;
    check("rsp_handshake", {31'd0, done}, 32'd1);
    check("rsp_latency", first, first_exp);
    check("bus_req_pattern", {31'd0, req_ok}, 32'd1);
    check("bus_addr_stable", {31'd0, addr_ok}, 32'd1);
    check("rsp_hold_stable", {31'd0, stable_ok}, 32'd1);
    // Back to idle right after the handshake; a stray rvalid here is dropped.
    lf.bus_rvalid = 1'b1; lf.bus_err = 1'b0;
    @(negedge clk);
    check("idle_after_rsp", {30'd0, lf.ld_ready, lf.rsp_valid}, 32'd2);
    @(posedge clk); #1;
    lf.bus_rvalid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ld_ready"}, {31'd0, lf.ld_ready}, 32'd1);
    check({tag, "_bus_req"}, {31'd0, lf.bus_req}, 32'd0);
    check({tag, "_bus_addr"}, lf.bus_addr, 32'd0);
    check({tag, "_rsp_valid"}, {31'd0, lf.rsp_valid}, 32'd0);
    check({tag, "_rsp_data"}, lf.rsp_data, 32'd0);
    check({tag, "_rsp_exc"}, {30'd0, lf.rsp_exc}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] t;
    logic [31:0] a;
    int gd, rd;
    lf.ld_valid = 0; lf.ld_addr = 0; lf.ld_type = 0; lf.ld_signed = 0;
    lf.bus_gnt = 0; lf.bus_rvalid = 0; lf.bus_rdata = 0; lf.bus_err = 0;
    lf.rsp_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Directed cases
    run_load(32'h0000_1003, Byte, 1, 32'h80FF_1234, 0, 0, 0, 0);
    run_load(32'h0000_1003, Byte, 0, 32'h80FF_1234, 0, 0, 0, 0);
    run_load(32'h0000_2002, Half, 0, 32'hBEEF_0001, 4, 0, 0, 1);
    run_load(32'h0000_2002, Half, 1, 32'hBEEF_0001, 4, 0, 0, 0);
    run_load(32'h0000_3001, Word, 0, 32'h1111_1111, 0, 0, 0, 0);
    run_load(32'h0000_3003, Half, 1, 32'h1111_1111, 0, 0, 0, 0);
    run_load(32'h0000_4000, Byte, 1, 32'hFFFF_FFFF, 1, 1, 1, 0);
    run_load(32'h0000_5004, Word, 0, 32'h1234_5678, -1, -1, 0, 2);
    run_load(32'h0000_5008, Word, 0, 32'h1234_5678, 2, -1, 0, 0);
    run_load(32'h0000_500C, Word, 0, 32'hCAFE_F00D, 3, 3, 0, 0);
    run_load(32'h0000_5010, Word, 0, 32'hCAFE_F00D, 4, 3, 0, 0);
    run_load(32'h0000_6001, 3'd7, 1, 32'hFFFF_FFFF, 0, 0, 0, 0);
    run_load(32'h0000_7002, Half, 1, 32'h7FFF_8000, 0, 2, 0, 5);

    // Randomized loads
    for (int i = 0; i < 50; i++) begin
      case ($urandom_range(0, 7))
        0, 1, 2: t = Byte;
        3, 4:    t = Half;
        5, 6:    t = Word;
        default: t = 3'($urandom_range(3, 7));
      endcase
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (t == Half) a[0] = 1'b0;
        if (t == Word) a[1:0] = 2'b00;
      end
      gd = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4));
      rd = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4));
      run_load(a, t, 1'($urandom), $urandom, gd, rd, ($urandom_range(0, 7) == 0),
               int'($urandom_range(0, 3)));
    end

    // Reset while in WAIT: outputs return to reset values immediately.
    lf.ld_valid = 1; lf.ld_addr = 32'h0000_0040; lf.ld_type = Byte; lf.ld_signed = 0;
    @(posedge clk); #1;
    lf.ld_valid = 0; lf.bus_gnt = 1;
    @(posedge clk); #1;
    lf.bus_gnt = 0;
    @(negedge clk);
    check("wait_bus_addr", lf.bus_addr, 32'h0000_0040);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst_wait");
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Reset while in REQ drops bus_req at once.
    lf.ld_valid = 1; lf.ld_addr = 32'h1234_5670; lf.ld_type = Word;
    @(posedge clk); #1;
    lf.ld_valid = 0;
    @(negedge clk);
    check("req_before_reset", {31'd0, lf.bus_req}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("req_async_drop", {31'd0, lf.bus_req}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    lf.bus_rvalid = 1; lf.bus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("post_reset_ready", {30'd0, lf.ld_ready, lf.rsp_valid}, 32'd2);
    @(posedge clk); #1;
    lf.bus_rvalid = 0;

    run_load(32'h0000_8001, Byte, 0, 32'h0000_A500, 1, 0, 0, 0);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/load_unit.md
# load_unit

Read-side counterpart of the store byte-enable path in the MEM stage of the pipelined CPU. It accepts one load at a time from the pipeline and checks alignment. It fetches the containing word over a variable-latency data bus, extracts the addressed byte or halfword, sign- or zero-extends it, and holds the result until writeback consumes it. The pipeline stalls MEM while `ld_ready` is low.

## Interface
- `TIMEOUT`, default 255: maximum cycles spent in REQ+WAIT before the load is aborted; must be ≥ 2.
- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ld_valid`  in  1  load request from MEM.
- `ld_ready`  out  1  unit idle and able to accept.
- `ld_addr`  in  32  byte address.
- `ld_type`  in  3  access size, using the shared `Word`/`Half`/`Byte` encodings.
- `ld_signed`  in  1  1 = sign-extend, 0 = zero-extend (ignored for `Word`).
- `bus_req`  out  1  read request, held until granted.
- `bus_addr`  out  32  `{addr[31:2], 2'b00}`, stable while `bus_req` is high.
- `bus_gnt`  in  1  request accepted.
- `bus_rvalid`  in  1  read data valid.
- `bus_rdata`  in  32  read word.
- `bus_err`  in  1  qualifies `bus_rvalid`; 1 = slave error.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  writeback consumes the result.
- `rsp_data`  out  32  extended load data.
- `rsp_exc`  out  2  exception code: `EXC_NONE`=0, `EXC_ADEL`=1, `EXC_BUS`=2, `EXC_TMO`=3.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- `ld_ready` = (state == IDLE). `bus_req` = (state == REQ). `rsp_valid` = (state == RESP). No other outputs are combinational from inputs.
- IDLE: on `ld_valid`, latch addr, type and signed, then branch:
  - `Half` with addr[0]=1, or `Word` with addr[1:0]≠0: go to RESP with `EXC_ADEL` and data 0. No bus access.
  - Type not `Word`/`Half`/`Byte`: go to RESP with `EXC_NONE` and data 0. No bus access.
  - Otherwise go to REQ and clear the timeout counter.
- REQ: on `bus_gnt`, go to WAIT. `bus_rvalid` is ignored in REQ; the bus never returns data in the grant cycle.
- WAIT: on `bus_rvalid`:
  - `bus_err`=1: go to RESP with `EXC_BUS` and data 0.
  - Otherwise register the extended `bus_rdata` and go to RESP with `EXC_NONE`.
- Timeout: the counter increments each cycle in REQ or WAIT. When it reaches TIMEOUT−1 without the exit condition, go to RESP with `EXC_TMO` and data 0. If `bus_rvalid`/`bus_gnt` arrives in that same cycle, the bus event wins.
- RESP: hold `rsp_data`/`rsp_exc` stable. On `rsp_ready`, go to IDLE. A late `bus_rvalid` in RESP or IDLE is dropped.
- Extraction:
  - `Byte`: lane addr[1:0].
  - `Half`: addr[1] selects bits [31:16] or [15:0].
  - Extend to 32 bits with the MSB of the field if signed, zeros if not.

## Timing
- Reset (asynchronous): state IDLE, `ld_ready`=1, `bus_req`=0, `bus_addr`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_exc`=0, counter 0.
- Reset mid-transaction aborts it immediately and `bus_req` drops asynchronously. The outstanding bus response is the bus's problem; the unit ignores it.
- Best-case latency:
  - Cycle 0: accept.
  - Cycle 1: `bus_req` high, `bus_gnt` high.
  - Cycle 2: `bus_rvalid` high.
  - Cycle 3: `rsp_valid` high.
- ADEL and bad-type loads: `rsp_valid` is high the cycle after accept.
- Back-to-back: with `rsp_ready`=1 in RESP, the unit is IDLE next cycle. A new load is accepted at the earliest one cycle after the response handshake.

## Structure
- Shared `Constants.v` carries `Word`/`Half`/`Byte` (already present) and the new `EXC_NONE`/`EXC_ADEL`/`EXC_BUS`/`EXC_TMO` and state encodings.
- One combinational sub-module, `load_extender`, with ports (`data_r_in`, `addr_low`, `read_type`, `sign_ext`) → `data_r_out`. It is reusable by the bypass path.
- Top level: FSM, latched request, timeout counter of width `$clog2(TIMEOUT+1)`, response registers.

## Test plan
- Signed `Byte`, addr 0x1003, rdata 0x80FF_1234, gnt cycle 1, rvalid cycle 2 → `rsp_valid` cycle 3, data 0xFFFF_FF80, exc 0. Repeat unsigned → 0x0000_0080.
- Unsigned `Half`, addr 0x2002, rdata 0xBEEF_0001, gnt delayed 4 cycles → `bus_addr` 0x2000 stable throughout, data 0x0000_BEEF. Signed → 0xFFFF_BEEF.
- `Word` at 0x3001 and `Half` at 0x3003 → no `bus_req`, `rsp_valid` next cycle, exc 1, data 0.
- rvalid with `bus_err`=1 → exc 2, data 0. Then `TIMEOUT`=8 with no gnt → exc 3 after 8 cycles in REQ. A later stray `bus_rvalid` is ignored.
- Hold `rsp_ready`=0 for 5 cycles → data and exc stable, `ld_ready`=0. Assert `reset_n`=0 while in WAIT → all outputs at reset values within the same cycle, `ld_ready`=1 after release.
